// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO responder (PHY side). MDC and MDIO are oversampled in the clk
// domain. All bit sampling and pad updates happen on a synchronized MDC rising
// edge. The block serves a 32 x 16-bit register file; registers 2 and 3 read as
// the PHY identifier and ignore writes.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (deassertion synchronized inside)
//   mdc_i      management clock from the bus master
//   mdio_i     MDIO pad input
//   mdio_o     MDIO pad output value
//   mdio_t     pad tristate: 1 = released, 0 = driving mdio_o
//   wr_strobe  one-clk pulse when a register write commits
//   wr_addr    register address of the last committed write
//   wr_data    data of the last committed write
//   frame_err  one-clk pulse on a malformed frame
module mdio_phy_responder #(
   parameter logic [4:0]  PHY_ADDR     = 5'd1,
   parameter logic [15:0] PHY_ID1      = 16'h0022,
   parameter logic [15:0] PHY_ID2      = 16'h1622,
   parameter int unsigned PREAMBLE_LEN = 32,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mdc_i,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_t,
   output logic        wr_strobe,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        frame_err
);

   localparam int unsigned PreW = $clog2(PREAMBLE_LEN + 1);
   localparam logic [PreW-1:0] PreMax = PreW'(PREAMBLE_LEN);

   typedef enum logic [3:0] {
      StIdle, StSt, StOp, StPhyad, StRegad, StTa, StWdata, StRdata, StSkip
   } state_e;

   // Reset: asserts asynchronously, releases two clk edges after rst_n rises.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   logic [SYNC_STAGES-1:0] mdc_sync_q, mdio_sync_q;
   logic                   mdc_prev_q;
   logic                   mdc_rise, bit_in;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         mdc_sync_q  <= '0;
         mdio_sync_q <= '1;
         mdc_prev_q  <= 1'b0;
      end else begin
         mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc_i};
         mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
         mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
      end
   end

   assign mdc_rise = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
   assign bit_in   = mdio_sync_q[SYNC_STAGES-1];

   state_e          state_q, state_d;
   logic [PreW-1:0] pre_q, pre_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            op_hi_q, op_hi_d, is_read_q, is_read_d, ta_hi_q, ta_hi_d;
   logic [4:0]      phyad_q, phyad_d, regad_q, regad_d;
   logic [15:0]     shift_q, shift_d;
   logic            mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
   logic            wr_strobe_q, wr_strobe_d, frame_err_q, frame_err_d;
   logic [4:0]      wr_addr_q, wr_addr_d;
   logic [15:0]     wr_data_q, wr_data_d;
   logic [15:0]     regs_q [32];
   logic            reg_we;
   logic [4:0]      regad_full;
   logic [15:0]     wdata_full, rd_val;

   assign regad_full = {regad_q[3:0], bit_in};
   assign wdata_full = {shift_q[14:0], bit_in};

   always_comb begin
      rd_val = regs_q[regad_full];
      if (regad_full == 5'd2)      rd_val = PHY_ID1;
      else if (regad_full == 5'd3) rd_val = PHY_ID2;
   end

   always_comb begin
      state_d     = state_q;
      pre_d       = pre_q;
      cnt_d       = cnt_q;
      op_hi_d     = op_hi_q;
      is_read_d   = is_read_q;
      ta_hi_d     = ta_hi_q;
      phyad_d     = phyad_q;
      regad_d     = regad_q;
      shift_d     = shift_q;
      mdio_o_d    = mdio_o_q;
      mdio_t_d    = mdio_t_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_strobe_d = 1'b0;
      frame_err_d = 1'b0;
      reg_we      = 1'b0;
      if (mdc_rise) begin
         unique case (state_q)
            StIdle: begin
               if (bit_in) begin
                  if (pre_q < PreMax) pre_d = pre_q + PreW'(1);
               end else begin
                  // A 0 either starts a frame or discards a short preamble.
                  if (pre_q >= PreMax) state_d = StSt;
                  pre_d = '0;
               end
            end
            StSt: begin
               if (bit_in) begin
                  state_d = StOp;
                  cnt_d   = 5'd1;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StIdle;
               end
            end
            StOp: begin
               if (cnt_q != 5'd0) begin
                  op_hi_d = bit_in;
                  cnt_d   = 5'd0;
               end else if (op_hi_q != bit_in) begin
                  is_read_d = op_hi_q;
                  state_d   = StPhyad;
                  cnt_d     = 5'd4;
               end else begin
                  // Rest of frame: PHYAD + REGAD + TA + data = 28 bits.
                  frame_err_d = 1'b1;
                  state_d     = StSkip;
                  cnt_d       = 5'd27;
               end
            end
            StPhyad: begin
               phyad_d = {phyad_q[3:0], bit_in};
               if (cnt_q == 5'd0) begin
                  state_d = StRegad;
                  cnt_d   = 5'd4;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            StRegad: begin
               regad_d = regad_full;
               if (cnt_q == 5'd0) begin
                  shift_d = rd_val;
                  cnt_d   = (phyad_q != PHY_ADDR) ? 5'd17 : 5'd1;
                  state_d = (phyad_q != PHY_ADDR) ? StSkip : StTa;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            StTa: begin
               if (cnt_q != 5'd0) begin
                  ta_hi_d = bit_in;
                  cnt_d   = 5'd0;
                  if (is_read_q) begin
                     mdio_t_d = 1'b0;
                     mdio_o_d = 1'b0;
                  end
               end else if (is_read_q) begin
                  mdio_o_d = shift_q[15];
                  shift_d  = {shift_q[14:0], 1'b0};
                  cnt_d    = 5'd15;
                  state_d  = StRdata;
               end else if ({ta_hi_q, bit_in} == 2'b10) begin
                  cnt_d   = 5'd15;
                  state_d = StWdata;
               end else begin
                  frame_err_d = 1'b1;
                  cnt_d       = 5'd15;
                  state_d     = StSkip;
               end
            end
            StWdata: begin
               shift_d = wdata_full;
               if (cnt_q == 5'd0) begin
                  state_d = StIdle;
                  if (regad_q != 5'd2 && regad_q != 5'd3) begin
                     reg_we      = 1'b1;
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = regad_q;
                     wr_data_d   = wdata_full;
                  end
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            StRdata: begin
               if (cnt_q == 5'd0) begin
                  mdio_t_d = 1'b1;
                  mdio_o_d = 1'b1;
                  state_d  = StIdle;
               end else begin
                  mdio_o_d = shift_q[15];
                  shift_d  = {shift_q[14:0], 1'b0};
                  cnt_d    = cnt_q - 5'd1;
               end
            end
            StSkip: begin
               if (cnt_q == 5'd0) state_d = StIdle;
               else               cnt_d   = cnt_q - 5'd1;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= StIdle;
         pre_q       <= '0;
         cnt_q       <= '0;
         op_hi_q     <= 1'b0;
         is_read_q   <= 1'b0;
         ta_hi_q     <= 1'b0;
         phyad_q     <= '0;
         regad_q     <= '0;
         shift_q     <= '0;
         mdio_o_q    <= 1'b1;
         mdio_t_q    <= 1'b1;
         wr_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         cnt_q       <= cnt_d;
         op_hi_q     <= op_hi_d;
         is_read_q   <= is_read_d;
         ta_hi_q     <= ta_hi_d;
         phyad_q     <= phyad_d;
         regad_q     <= regad_d;
         shift_q     <= shift_d;
         mdio_o_q    <= mdio_o_d;
         mdio_t_q    <= mdio_t_d;
         wr_strobe_q <= wr_strobe_d;
         frame_err_q <= frame_err_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         if (reg_we) regs_q[regad_q] <= wdata_full;
      end
   end

   assign mdio_o    = mdio_o_q;
   assign mdio_t    = mdio_t_q;
   assign wr_strobe = wr_strobe_q;
   assign frame_err = frame_err_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule
